memory_arbiter: RTL and testbench

Sequential arbiter that shares the single RAM port between the instruction-fetch path and the data-memory path of the pipelined datapath. Requests are granted one at a time, with data priority and a bounded-starvation guarantee for instruction fetch. Address and store data are held stable for the whole transaction. After halt, instruction fetch is blocked and data traffic (cache flush) continues to be served.

---
 rtl/arb_pkg.sv | 18 +
 rtl/memory_arbiter.sv | 157 +++++++++++++++
 tb/tb_memory_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the RAM-port arbiter.
// Word type, arbiter state encoding and starvation defaults.
package arb_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 4;
  localparam int unsigned CNT_W = 4;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data memory.
// Ports: CLK/nRST; iREN,iaddr -> iload,ihit; dREN,dWEN,daddr,dstore
// -> dload,dhit; halt; ramREN,ramWEN,ramaddr,ramstore <- ramload,ram_ready.
module memory_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output word_t iload,
  output logic  ihit,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output word_t dload,
  output logic  dhit,
  input  logic  halt,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ram_ready
);

  localparam cnt_t LP_SMAX = cnt_t'(STARVE_MAX);

  arb_state_t r_state;
  arb_state_t w_next;

  word_t r_addr;
  word_t r_store;
  logic  r_wr;
  cnt_t  r_starve;
  logic  r_halted;

  logic w_iwant;
  logic w_dwant;
  logic w_force_i;
  logic w_dheld;
  logic w_sel_d;
  logic w_sel_i;

  always_comb begin
    w_iwant   = iREN & ~r_halted;
    w_dwant   = dREN | dWEN;
    w_force_i = w_iwant & (r_starve == LP_SMAX);
    // A write grant is held by dWEN, a read grant by dREN.
    w_dheld   = r_wr ? dWEN : dREN;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_sel_d  = 1'b0;
    w_sel_i  = 1'b0;
    ihit     = 1'b0;
    iload    = '0;
    dhit     = 1'b0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (r_state)
      IDLE: begin
        if (w_dwant && !w_force_i) begin
          w_next  = DGNT;
          w_sel_d = 1'b1;
        end else if (w_iwant) begin
          w_next  = IGNT;
          w_sel_i = 1'b1;
        end
      end
      IGNT: begin
        // Fetch in flight finishes even if halt rose meanwhile.
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = r_addr;
          if (ram_ready) begin
            ihit   = 1'b1;
            iload  = ramload;
            w_next = IDLE;
          end
        end
      end
      DGNT: begin
        if (!w_dheld) begin
          w_next = IDLE;
        end else begin
          ramWEN   = r_wr;
          ramREN   = ~r_wr;
          ramaddr  = r_addr;
          ramstore = r_store;
          if (ram_ready) begin
            dhit   = 1'b1;
            dload  = r_wr ? '0 : ramload;
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
    end else if (w_sel_d) begin
      r_addr  <= daddr;
      r_store <= dstore;
      r_wr    <= dWEN;
    end else if (w_sel_i) begin
      r_addr  <= iaddr;
      r_store <= '0;
      r_wr    <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halted <= 1'b0;
    end else if (halt) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_starve <= '0;
    end else if (ihit) begin
      r_starve <= '0;
    end else if (dhit && w_iwant) begin
      if (r_starve != LP_SMAX) begin
        r_starve <= r_starve + 4'd1;
      end
    end else if (r_state == IDLE && !iREN) begin
      r_starve <= '0;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: vector table, corner sequences,
// and random traffic against a transaction-level model.
module tb_memory_arbiter;
  import arb_pkg::*;

  localparam int SMAX = 4;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  iREN, dREN, dWEN, halt, ram_ready;
  word_t iaddr, daddr, dstore, ramload;
  word_t iload, dload, ramaddr, ramstore;
  logic  ihit, dhit, ramREN, ramWEN;

  always #5 CLK = ~CLK;

  memory_arbiter #(.STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ram_ready(ram_ready)
  );

  typedef struct packed {
    logic  ihit;
    word_t iload;
    logic  dhit;
    word_t dload;
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } outs_t;

  typedef struct packed {
    logic  iren;
    word_t iaddr;
    logic  dren;
    logic  dwen;
    word_t daddr;
    word_t dstore;
    logic  halt;
    logic  rr;
    word_t rl;
    outs_t exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vt[$];

  function automatic outs_t mk(input logic ih, input word_t il,
                               input logic dh, input word_t dl,
                               input logic rn, input logic wn,
                               input word_t a, input word_t s);
    outs_t o;
    o.ihit = ih; o.iload = il; o.dhit = dh; o.dload = dl;
    o.ren = rn; o.wen = wn; o.addr = a; o.store = s;
    return o;
  endfunction

  function automatic outs_t sample();
    return mk(ihit, iload, dhit, dload, ramREN, ramWEN,
              ramaddr, ramstore);
  endfunction

  task automatic chk(input string name, input logic [131:0] act,
                     input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic ir, input word_t ia,
                      input logic dr, input logic dw,
                      input word_t da, input word_t ds,
                      input logic h, input logic rr,
                      input word_t rl, input outs_t e);
    vec_t v;
    v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw;
    v.daddr = da; v.dstore = ds; v.halt = h; v.rr = rr;
    v.rl = rl; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic zero_in();
    iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0;
    dstore = '0; halt = 0; ram_ready = 0; ramload = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    zero_in();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("reset_outs", sample(), '0);
    chk("reset_state", 132'(dut.r_state), 132'(IDLE));
    @(posedge CLK);
    #1;
  endtask

  // Reference model state: who owns the port, latched request,
  // consecutive data grants seen while fetch waits, halt latch.
  int    m_owner;
  word_t m_addr, m_store;
  bit    m_wr, m_halted;
  int    m_starve;

  function automatic outs_t model_out();
    outs_t e;
    bit held;
    e = '0;
    if (m_owner == 1 && iREN) begin
      e.ren = 1; e.addr = m_addr;
      if (ram_ready) begin e.ihit = 1; e.iload = ramload; end
    end
    if (m_owner == 2) begin
      held = m_wr ? dWEN : dREN;
      if (held) begin
        e.wen = m_wr; e.ren = !m_wr;
        e.addr = m_addr; e.store = m_store;
        if (ram_ready) begin
          e.dhit = 1;
          e.dload = m_wr ? '0 : ramload;
        end
      end
    end
    return e;
  endfunction

  task automatic model_step();
    bit iw, held;
    iw = iREN && !m_halted;
    if (m_owner == 0) begin
      if (!iREN) m_starve = 0;
      if ((dREN || dWEN) && !(iw && m_starve == SMAX)) begin
        m_owner = 2; m_addr = daddr;
        m_store = dstore; m_wr = dWEN;
      end else if (iw) begin
        m_owner = 1; m_addr = iaddr;
      end
    end else if (m_owner == 1) begin
      if (iREN && ram_ready) m_starve = 0;
      if (!iREN || ram_ready) m_owner = 0;
    end else begin
      held = m_wr ? dWEN : dREN;
      if (held && ram_ready && iw)
        m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
      if (!held || ram_ready) m_owner = 0;
    end
    if (halt) m_halted = 1;
  endtask

  initial begin
    outs_t z;
    int ev[$];
    int got, want, nih, ndh;
    bit starve_seen;
    z = '0;
    zero_in();
    do_reset();

    addv(1, 'h40, 0, 0, 0, 0, 0, 0, 0, z);
    addv(1, 'h40, 0, 0, 0, 0, 0, 0, 'h11,
         mk(0, 0, 0, 0, 1, 0, 'h40, 0));
    addv(1, 'h40, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,
         mk(1, 'hDEADBEEF, 0, 0, 1, 0, 'h40, 0));
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, z);
    addv(1, 'h80, 0, 1, 'h100, 'h1234, 0, 0, 0, z);
    addv(1, 'h80, 0, 1, 'h100, 'h1234, 0, 1, 'h99,
         mk(0, 0, 1, 0, 0, 1, 'h100, 'h1234));
    addv(1, 'h80, 0, 0, 0, 0, 0, 0, 0, z);
    addv(1, 'h80, 0, 0, 0, 0, 0, 1, 'h55,
         mk(1, 'h55, 0, 0, 1, 0, 'h80, 0));
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, z);
    addv(0, 0, 1, 0, 'h200, 0, 0, 0, 0, z);
    addv(0, 0, 1, 0, 'h200, 0, 0, 0, 0,
         mk(0, 0, 0, 0, 1, 0, 'h200, 0));
    addv(0, 0, 0, 0, 'h200, 0, 0, 1, 'h33, z);
    addv(0, 0, 0, 0, 0, 0, 0, 1, 'h33, z);
    addv(0, 0, 1, 1, 'h300, 'hAA, 0, 0, 0, z);
    addv(0, 0, 1, 1, 'h300, 'hAA, 0, 1, 'h44,
         mk(0, 0, 1, 0, 0, 1, 'h300, 'hAA));
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, z);

    foreach (vt[i]) begin
      iREN = vt[i].iren; iaddr = vt[i].iaddr;
      dREN = vt[i].dren; dWEN = vt[i].dwen;
      daddr = vt[i].daddr; dstore = vt[i].dstore;
      halt = vt[i].halt; ram_ready = vt[i].rr;
      ramload = vt[i].rl;
      @(negedge CLK);
      chk($sformatf("vec%0d", i), sample(), vt[i].exp);
      @(posedge CLK);
      #1;
    end

    // Starvation bound: 4 data hits, then fetch, then data.
    iREN = 1; iaddr = 'h500; dREN = 1; daddr = 'h600;
    ram_ready = 1; ramload = 'h77;
    starve_seen = 0;
    for (int c = 0; c < 30 && ev.size() < 6; c++) begin
      @(negedge CLK);
      if (dhit) ev.push_back(2);
      if (ihit) ev.push_back(1);
      @(posedge CLK);
      #1;
      if (ihit === 1'b0 && ev.size() == 5 && !starve_seen) begin
        starve_seen = 1;
        chk("starve_clear", 132'(dut.r_starve), 132'(0));
      end
    end
    got = 0;
    foreach (ev[k]) got = got * 10 + ev[k];
    want = 222212;
    chk("starve_order", 132'(got), 132'(want));
    zero_in();
    @(posedge CLK);
    #1;

    // Halt during an in-flight fetch.
    do_reset();
    iREN = 1; iaddr = 'h900;
    @(posedge CLK);
    #1;
    halt = 1;
    @(negedge CLK);
    chk("halt_ignt", sample(), mk(0, 0, 0, 0, 1, 0, 'h900, 0));
    @(posedge CLK);
    #1;
    halt = 0; ram_ready = 1; ramload = 'hCAFE;
    @(negedge CLK);
    chk("halt_ihit", sample(),
        mk(1, 'hCAFE, 0, 0, 1, 0, 'h900, 0));
    @(posedge CLK);
    #1;
    dWEN = 1; daddr = 'hA00; dstore = 5;
    nih = 0; ndh = 0;
    repeat (20) begin
      @(negedge CLK);
      nih += int'(ihit);
      ndh += int'(dhit);
      @(posedge CLK);
      #1;
    end
    chk("halt_no_ihit", 132'(nih), 132'(0));
    chk("halt_dhits", 132'(ndh), 132'(10));

    // Asynchronous reset in the middle of a data write.
    do_reset();
    dWEN = 1; daddr = 'hB00; dstore = 'h99;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("rst_pre", sample(), mk(0, 0, 0, 0, 0, 1, 'hB00, 'h99));
    #1;
    nRST = 0;
    #1;
    chk("rst_async", sample(), '0);
    dWEN = 0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    #1;
    chk("rst_rel_outs", sample(), '0);
    chk("rst_rel_state", 132'(dut.r_state), 132'(IDLE));
    @(posedge CLK);
    #1;

    // Random traffic against the model.
    do_reset();
    m_owner = 0; m_addr = '0; m_store = '0;
    m_wr = 0; m_halted = 0; m_starve = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 3) == 0) dREN = ~dREN;
      if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
      iaddr = $urandom; daddr = $urandom;
      dstore = $urandom; ramload = $urandom;
      ram_ready = ($urandom_range(0, 2) != 0);
      halt = (c > 600) && ($urandom_range(0, 40) == 0);
      @(negedge CLK);
      chk($sformatf("rand%0d", c), sample(), model_out());
      @(posedge CLK);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
